// File: rtl/uart_frame_ctrl_if.sv
// FIFO-side and UART-TX-side signals of the frame controller.
// The master modport is the controller; the slave modport is the FIFOs plus transmitter.
interface uart_frame_ctrl_if #(
    parameter int CH = 2,
    parameter int DW = 8
);
    logic [CH-1:0]    fifo_empty;
    logic [CH*DW-1:0] fifo_data;
    logic [CH-1:0]    fifo_rd;
    logic             tx_busy;
    logic             tx_start;
    logic [7:0]       tx_data;

    modport master (
        input  fifo_empty, fifo_data, tx_busy,
        output fifo_rd, tx_start, tx_data
    );

    modport slave (
        output fifo_empty, fifo_data, tx_busy,
        input  fifo_rd, tx_start, tx_data
    );
endinterface

// File: rtl/uart_frame_ctrl.sv
// Drains CH sample FIFOs into an 8-bit UART TX as frames:
// an optional header byte, then each channel sample MSB-first.
module uart_frame_ctrl #(
    parameter int         CH        = 2,
    parameter int         DW        = 8,
    parameter int         HEADER_EN = 1,
    parameter logic [7:0] HEADER    = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            gather_set,
    uart_frame_ctrl_if.master     bus,
    output logic                  frame_done,
    output logic [15:0]           frame_cnt,
    output logic                  idle
);
    localparam int BPC  = DW / 8;
    localparam int NDB  = CH * BPC;
    localparam int HOFF = (HEADER_EN != 0) ? 1 : 0;
    localparam int NB   = HOFF + NDB;
    localparam int IW   = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_LAT, S_SEND, S_WAIT_HI, S_WAIT_LO, S_DONE
    } state_t;

    state_t           state_reg;
    logic [CH*DW-1:0] shadow_reg;
    logic [IW-1:0]    idx_reg;
    logic [7:0]       tx_data_reg;
    logic [CH-1:0]    fifo_rd_reg;
    logic             frame_done_reg;
    logic [15:0]      frame_cnt_reg;
    logic             idle_reg;
    logic             armed_reg;
    logic             gs10_prev_reg;

    logic [CH*DW-1:0] byte_src;
    logic [IW-1:0]    load_idx;
    logic [7:0]       frame_bytes [NB];
    logic             gs_is10;
    logic             start_ok;

    assign gs_is10  = (gather_set == 2'b10);
    assign start_ok = ((gather_set == 2'b01) || armed_reg) && (bus.fifo_empty == '0);

    // In LAT the first byte is taken straight from the FIFO word being captured.
    always_comb begin
        byte_src = shadow_reg;
        load_idx = '0;
        if (state_reg == S_LAT)
            byte_src = bus.fifo_data;
        if (state_reg == S_WAIT_LO)
            load_idx = idx_reg + 1'b1;
    end

    generate
        if (HEADER_EN != 0) begin : g_hdr
            assign frame_bytes[0] = HEADER;
        end
        for (genvar gi = 0; gi < NDB; gi++) begin : g_bytes
            assign frame_bytes[HOFF + gi] =
                byte_src[(gi / BPC) * DW + DW - 8 - (gi % BPC) * 8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            shadow_reg     <= '0;
            idx_reg        <= '0;
            tx_data_reg    <= 8'h00;
            fifo_rd_reg    <= '0;
            frame_done_reg <= 1'b0;
            frame_cnt_reg  <= 16'd0;
            idle_reg       <= 1'b1;
            armed_reg      <= 1'b0;
            gs10_prev_reg  <= 1'b0;
        end else begin
            gs10_prev_reg  <= gs_is10;
            fifo_rd_reg    <= '0;
            frame_done_reg <= 1'b0;
            if (gs_is10 && !gs10_prev_reg)
                armed_reg <= 1'b1;

            case (state_reg)
                S_IDLE: begin
                    if (start_ok) begin
                        state_reg   <= S_RD;
                        fifo_rd_reg <= '1;
                        idle_reg    <= 1'b0;
                        armed_reg   <= 1'b0;
                    end
                end
                S_RD: state_reg <= S_LAT;
                S_LAT: begin
                    shadow_reg  <= bus.fifo_data;
                    idx_reg     <= '0;
                    tx_data_reg <= frame_bytes[load_idx];
                    state_reg   <= S_SEND;
                end
                S_SEND: begin
                    if (!bus.tx_busy)
                        state_reg <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (bus.tx_busy)
                        state_reg <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    if (!bus.tx_busy) begin
                        if (idx_reg == IW'(NB - 1)) begin
                            state_reg      <= S_DONE;
                            frame_done_reg <= 1'b1;
                        end else begin
                            idx_reg     <= load_idx;
                            tx_data_reg <= frame_bytes[load_idx];
                            state_reg   <= S_SEND;
                        end
                    end
                end
                S_DONE: begin
                    frame_cnt_reg <= frame_cnt_reg + 16'd1;
                    idle_reg      <= 1'b1;
                    state_reg     <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                    idle_reg  <= 1'b1;
                end
            endcase
        end
    end

    // The request is qualified by tx_busy in the SEND cycle itself, so the first
    // byte goes out three cycles after the start condition when the UART is free.
    assign bus.tx_start = (state_reg == S_SEND) && !bus.tx_busy;
    assign bus.tx_data  = tx_data_reg;
    assign bus.fifo_rd  = fifo_rd_reg;
    assign frame_done   = frame_done_reg;
    assign frame_cnt    = frame_cnt_reg;
    assign idle         = idle_reg;
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed bench for uart_frame_ctrl (CH=2, DW=16, header A5) with a
// normal-mode FIFO model and a UART model that stays busy 10 cycles per byte.
module tb_uart_frame_ctrl;
    localparam int CH = 2;
    localparam int DW = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  gather_set = 2'b00;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        idle;

    uart_frame_ctrl_if #(.CH(CH), .DW(DW)) bus_if ();

    uart_frame_ctrl #(.CH(CH), .DW(DW), .HEADER_EN(1), .HEADER(8'hA5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gather_set (gather_set),
        .bus        (bus_if),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // FIFO and UART models
    int               busy_cnt = 0;
    logic             busy_force = 1'b0;
    int               rd_count = 0;
    int               words_loaded = 0;
    logic [CH-1:0]    empty_force = '0;
    logic [CH*DW-1:0] fdata = 32'hDEADBEEF;

    assign bus_if.tx_busy    = (busy_cnt != 0) | busy_force;
    assign bus_if.fifo_empty = {CH{rd_count >= words_loaded}} | empty_force;
    assign bus_if.fifo_data  = fdata;

    always @(posedge clk) begin
        if (bus_if.tx_start) busy_cnt <= 10;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        if (bus_if.fifo_rd != '0) begin
            fdata    <= {16'hABCD, 16'h1234};
            rd_count <= rd_count + 1;
        end else begin
            fdata <= 32'hDEADBEEF;
        end
    end

    // Monitor
    int         cyc = 0;
    logic [7:0] tx_log [$];
    int         rd_pulses = 0, done_pulses = 0, start_pulses = 0;
    int         consec_err = 0, partial_rd = 0;
    int         rd_gap = -1, last_done_cyc = -100;
    logic       prev_rd = 1'b0, prev_start = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (bus_if.tx_start) begin
            tx_log.push_back(bus_if.tx_data);
            start_pulses++;
            $display("tx byte %02h at cycle %0d", bus_if.tx_data, cyc);
        end
        if (bus_if.fifo_rd != '0) begin
            rd_pulses++;
            rd_gap = cyc - last_done_cyc;
            if (bus_if.fifo_rd != 2'b11) partial_rd++;
        end
        if (frame_done) begin
            done_pulses++;
            last_done_cyc = cyc;
        end
        if ((bus_if.tx_start && prev_start) || ((bus_if.fifo_rd != '0) && prev_rd))
            consec_err++;
        prev_start = bus_if.tx_start;
        prev_rd    = (bus_if.fifo_rd != '0);
    end

    logic [7:0] exp_b [5] = '{8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD};

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        gather_set  = 2'b00;
        busy_force  = 1'b0;
        empty_force = '0;
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(12);
        words_loaded = rd_count;
    endtask

    task automatic wait_done(input int target, input int max_cyc, output bit ok);
        int i = 0;
        while (done_pulses < target && i < max_cyc) begin
            step(1);
            i++;
        end
        ok = (done_pulses >= target);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(2);
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b exp=1", idle); end
        total++; if (bus_if.fifo_rd !== 2'b00) begin bad++; $display("FAIL reset_fifo_rd got=%b exp=00", bus_if.fifo_rd); end
        total++; if (bus_if.tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start got=%b exp=0", bus_if.tx_start); end
        total++; if (bus_if.tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%02h exp=00", bus_if.tx_data); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_basic_frame();
        int b_log, b_rd, b_done;
        bit ok;
        do_reset();
        b_log = tx_log.size(); b_rd = rd_pulses; b_done = done_pulses;
        words_loaded = rd_count + 1;
        gather_set = 2'b01;
        wait_done(b_done + 1, 500, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_timeout got=no_frame_done exp=frame_done"); end
        step(20);
        total++; if (tx_log.size() - b_log != 5) begin bad++; $display("FAIL basic_nbytes got=%0d exp=5", tx_log.size() - b_log); end
        for (int i = 0; i < 5; i++) begin
            if (b_log + i < tx_log.size()) begin
                total++;
                if (tx_log[b_log + i] !== exp_b[i]) begin bad++; $display("FAIL basic_byte%0d got=%02h exp=%02h", i, tx_log[b_log + i], exp_b[i]); end
            end
        end
        total++; if (rd_pulses - b_rd != 1) begin bad++; $display("FAIL basic_rd_pulses got=%0d exp=1", rd_pulses - b_rd); end
        total++; if (done_pulses - b_done != 1) begin bad++; $display("FAIL basic_done_pulses got=%0d exp=1", done_pulses - b_done); end
        total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL basic_frame_cnt got=%0d exp=1", frame_cnt); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL basic_idle_after got=%b exp=1", idle); end
    endtask

    task automatic test_empty_gate();
        int b_log, b_rd, b_st;
        bit ok;
        do_reset();
        b_rd = rd_pulses; b_st = start_pulses;
        words_loaded = rd_count + 1;
        empty_force = 2'b10;
        gather_set = 2'b01;
        step(1000);
        total++; if (rd_pulses != b_rd) begin bad++; $display("FAIL gate_no_rd got=%0d exp=0", rd_pulses - b_rd); end
        total++; if (start_pulses != b_st) begin bad++; $display("FAIL gate_no_start got=%0d exp=0", start_pulses - b_st); end
        b_log = tx_log.size();
        empty_force = 2'b00;
        @(negedge clk);
        total++; if (bus_if.fifo_rd !== 2'b00 || idle !== 1'b1) begin bad++; $display("FAIL lat_T got=rd%b/idle%b exp=rd00/idle1", bus_if.fifo_rd, idle); end
        @(negedge clk);
        total++; if (bus_if.fifo_rd !== 2'b11 || idle !== 1'b0) begin bad++; $display("FAIL lat_T1 got=rd%b/idle%b exp=rd11/idle0", bus_if.fifo_rd, idle); end
        @(negedge clk);
        total++; if (bus_if.fifo_rd !== 2'b00 || bus_if.tx_start !== 1'b0) begin bad++; $display("FAIL lat_T2 got=rd%b/st%b exp=rd00/st0", bus_if.fifo_rd, bus_if.tx_start); end
        @(negedge clk);
        total++; if (bus_if.tx_start !== 1'b1 || bus_if.tx_data !== 8'hA5) begin bad++; $display("FAIL lat_T3 got=st%b/%02h exp=st1/a5", bus_if.tx_start, bus_if.tx_data); end
        step(1);
        wait_done(done_pulses + 1, 500, ok);
        total++; if (!ok) begin bad++; $display("FAIL gate_timeout got=no_frame_done exp=frame_done"); end
        step(5);
        total++; if (tx_log.size() - b_log != 5) begin bad++; $display("FAIL gate_nbytes got=%0d exp=5", tx_log.size() - b_log); end
        else begin
            total++; if (tx_log[b_log + 4] !== 8'hCD) begin bad++; $display("FAIL gate_last_byte got=%02h exp=cd", tx_log[b_log + 4]); end
        end
    endtask

    task automatic test_single_shot();
        int b_rd, b_done;
        do_reset();
        b_rd = rd_pulses; b_done = done_pulses;
        words_loaded = rd_count + 3;
        gather_set = 2'b10;
        step(400);
        total++; if (done_pulses - b_done != 1) begin bad++; $display("FAIL single_frames got=%0d exp=1", done_pulses - b_done); end
        total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL single_cnt1 got=%0d exp=1", frame_cnt); end
        total++; if (rd_pulses - b_rd != 1) begin bad++; $display("FAIL single_rd1 got=%0d exp=1", rd_pulses - b_rd); end
        gather_set = 2'b00;
        step(3);
        gather_set = 2'b10;
        step(400);
        total++; if (frame_cnt !== 16'd2) begin bad++; $display("FAIL single_cnt2 got=%0d exp=2", frame_cnt); end
        total++; if (rd_pulses - b_rd != 2) begin bad++; $display("FAIL single_rd2 got=%0d exp=2", rd_pulses - b_rd); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int b_rd;
        do_reset();
        b_rd = rd_pulses;
        words_loaded = rd_count + 2;
        gather_set = 2'b01;
        wait_done(done_pulses + 2, 600, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_timeout got=no_frame_done exp=frame_done"); end
        total++; if (rd_gap != 2) begin bad++; $display("FAIL b2b_rd_gap got=%0d exp=2", rd_gap); end
        total++; if (rd_pulses - b_rd != 2) begin bad++; $display("FAIL b2b_rd got=%0d exp=2", rd_pulses - b_rd); end
        total++; if (frame_cnt !== 16'd2) begin bad++; $display("FAIL b2b_cnt got=%0d exp=2", frame_cnt); end
    endtask

    task automatic test_mode_change();
        int b_log, b_rd, i;
        bit ok;
        do_reset();
        b_log = tx_log.size(); b_rd = rd_pulses;
        words_loaded = rd_count + 3;
        gather_set = 2'b01;
        i = 0;
        while (tx_log.size() < b_log + 2 && i < 200) begin step(1); i++; end
        total++; if (tx_log.size() < b_log + 2) begin bad++; $display("FAIL mode_reach_byte2 got=%0d exp=2", tx_log.size() - b_log); end
        gather_set = 2'b00;
        wait_done(done_pulses + 1, 500, ok);
        total++; if (!ok) begin bad++; $display("FAIL mode_timeout got=no_frame_done exp=frame_done"); end
        step(200);
        total++; if (tx_log.size() - b_log != 5) begin bad++; $display("FAIL mode_nbytes got=%0d exp=5", tx_log.size() - b_log); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL mode_idle got=%b exp=1", idle); end
        total++; if (rd_pulses - b_rd != 1) begin bad++; $display("FAIL mode_rd got=%0d exp=1", rd_pulses - b_rd); end
    endtask

    task automatic test_busy_hold();
        int b_st, b_log;
        bit ok;
        do_reset();
        b_st = start_pulses; b_log = tx_log.size();
        busy_force = 1'b1;
        words_loaded = rd_count + 1;
        gather_set = 2'b01;
        step(20);
        total++; if (start_pulses != b_st) begin bad++; $display("FAIL busy_no_start got=%0d exp=0", start_pulses - b_st); end
        busy_force = 1'b0;
        @(negedge clk);
        total++; if (bus_if.tx_start !== 1'b1 || bus_if.tx_data !== 8'hA5) begin bad++; $display("FAIL busy_release got=st%b/%02h exp=st1/a5", bus_if.tx_start, bus_if.tx_data); end
        @(negedge clk);
        total++; if (bus_if.tx_start !== 1'b0) begin bad++; $display("FAIL busy_single_pulse got=%b exp=0", bus_if.tx_start); end
        step(1);
        wait_done(done_pulses + 1, 500, ok);
        total++; if (!ok) begin bad++; $display("FAIL busy_timeout got=no_frame_done exp=frame_done"); end
        step(2);
        total++; if (start_pulses - b_st != 5) begin bad++; $display("FAIL busy_starts got=%0d exp=5", start_pulses - b_st); end
        total++; if (tx_log.size() - b_log != 5) begin bad++; $display("FAIL busy_nbytes got=%0d exp=5", tx_log.size() - b_log); end
    endtask

    task automatic test_reset_midframe();
        int b_log, i;
        bit ok;
        do_reset();
        b_log = tx_log.size();
        words_loaded = rd_count + 2;
        gather_set = 2'b01;
        i = 0;
        while (tx_log.size() < b_log + 3 && i < 300) begin step(1); i++; end
        total++; if (tx_log.size() < b_log + 3) begin bad++; $display("FAIL rst_reach_byte3 got=%0d exp=3", tx_log.size() - b_log); end
        step(4);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL rstmid_idle got=%b exp=1", idle); end
        total++; if (bus_if.tx_data !== 8'h00) begin bad++; $display("FAIL rstmid_tx_data got=%02h exp=00", bus_if.tx_data); end
        total++; if (bus_if.tx_start !== 1'b0 || bus_if.fifo_rd !== 2'b00) begin bad++; $display("FAIL rstmid_strobes got=st%b/rd%b exp=st0/rd00", bus_if.tx_start, bus_if.fifo_rd); end
        total++; if (frame_cnt !== 16'd0 || frame_done !== 1'b0) begin bad++; $display("FAIL rstmid_cnt got=%0d/%b exp=0/0", frame_cnt, frame_done); end
        step(3);
        b_log = tx_log.size();
        rst_n = 1'b1;
        wait_done(done_pulses + 1, 500, ok);
        total++; if (!ok) begin bad++; $display("FAIL rstmid_timeout got=no_frame_done exp=frame_done"); end
        step(2);
        total++; if (tx_log.size() - b_log != 5) begin bad++; $display("FAIL rstmid_nbytes got=%0d exp=5", tx_log.size() - b_log); end
        else begin
            total++; if (tx_log[b_log] !== 8'hA5) begin bad++; $display("FAIL rstmid_first_byte got=%02h exp=a5", tx_log[b_log]); end
        end
        total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL rstmid_cnt_after got=%0d exp=1", frame_cnt); end
    endtask

    task automatic test_protocol();
        total++; if (consec_err != 0) begin bad++; $display("FAIL consecutive_strobes got=%0d exp=0", consec_err); end
        total++; if (partial_rd != 0) begin bad++; $display("FAIL partial_fifo_rd got=%0d exp=0", partial_rd); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_empty_gate();
        test_single_shot();
        test_back_to_back();
        test_mode_change();
        test_busy_hold();
        test_reset_midframe();
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_frame_ctrl.md
# uart_frame_ctrl

Parametrised successor to the single-channel FIFO-to-UART read/transmit synchroniser. It drains CH sample FIFOs (each DW bits wide) into an 8-bit UART transmitter as aligned frames: an optional sync header byte, then one sample per channel, MSB-first. It sits between the per-channel sample FIFOs and the UART TX, gated by the gather mode setting. It adds continuous and single-shot modes, a frame counter and an asynchronous reset.

## Interface
- CH, 2, number of channels (1..4)
- DW, 8, sample width in bits; must be a multiple of 8 (8 or 16)
- HEADER_EN, 1, 1 = prepend the header byte to each frame
- HEADER, 8'hA5, header byte value

- clk  input  1  system clock; all logic on the rising edge
- rst_n  input  1  asynchronous active-low reset
- gather_set  input  2  01 = continuous, 10 = single-shot, 00/11 = disabled
- fifo_empty  input  CH  per-channel FIFO empty flag
- fifo_data  input  CH*DW  channel k at bits [k*DW +: DW]; valid the cycle after fifo_rd (normal-mode FIFO)
- fifo_rd  output  CH  read strobe; all bits pulse together
- tx_busy  input  1  UART transmitter busy
- tx_start  output  1  one-cycle transmit request
- tx_data  output  8  byte to transmit; valid while tx_start=1
- frame_done  output  1  one-cycle pulse when the last byte of a frame completes
- frame_cnt  output  16  completed frames; wraps at 65535 -> 0
- idle  output  1  1 when the FSM is in IDLE

## Operation
- NB = HEADER_EN + CH*DW/8 bytes per frame. Byte order: header (if enabled), ch0 MSB..LSB, ch1 MSB..LSB, ...
- FSM states: IDLE, RD, LAT, SEND, WAIT_HI, WAIT_LO, DONE.
- IDLE -> RD when the frame is permitted and every fifo_empty bit is 0. Partial frames are never started.
  - Permitted in continuous mode: gather_set==01.
  - Permitted in single-shot mode: the armed flag is set.
- Armed flag: set on the first cycle gather_set==10 following any cycle where it was not 10; cleared on entering RD.
- RD: fifo_rd = all ones for exactly one cycle -> LAT.
- LAT: capture all of fifo_data into a CH*DW shadow register; byte index = 0 -> SEND.
- SEND: if tx_busy==0, assert tx_start for one cycle with tx_data = byte[index] -> WAIT_HI; otherwise hold, with no tx_start.
- WAIT_HI: wait for tx_busy==1 -> WAIT_LO.
- WAIT_LO: wait for tx_busy==0. Then if index == NB-1 -> DONE; else index+1 -> SEND.
- DONE: frame_done=1 for one cycle; frame_cnt+1 -> IDLE.
- A mode change mid-frame does not abort the frame. Gating applies only in IDLE.
- fifo_empty is sampled only in IDLE. Later changes are ignored until the next frame.

## Timing
- Reset values: state IDLE, fifo_rd=0, tx_start=0, tx_data=8'h00, frame_done=0, frame_cnt=0, idle=1, armed=0, shadow=0.
- Reset mid-frame returns to IDLE immediately. No pending read or transmit is issued after release.
- Latency from the start condition: condition true in IDLE at cycle T; fifo_rd at T+1; capture at T+2; first tx_start at T+3 if tx_busy==0.
- tx_start and the fifo_rd bits are never high for two consecutive cycles.
- At most one frame is in flight. Exactly one fifo_rd pulse per frame.
- Back-to-back frames: the earliest next fifo_rd is 2 cycles after frame_done (DONE -> IDLE -> RD).
- idle is registered with the state; it falls in the RD cycle.

## Test plan
- CH=2, DW=16, HEADER_EN=1, gather_set=01; FIFO words ch0=16'h1234, ch1=16'hABCD; TX model busy for 10 cycles after start -> tx_data sequence A5,12,34,AB,CD; one fifo_rd pulse; frame_done once; frame_cnt=1.
- Same setup with fifo_empty[1]=1 -> no fifo_rd and no tx_start for 1000 cycles. Clear it -> fifo_rd at the 2nd cycle after the clear is sampled in IDLE.
- gather_set=10 held with both FIFOs holding 3 words -> exactly 1 frame and frame_cnt=1. gather_set 10->00->10 -> a second frame; frame_cnt=2.
- Switch gather_set 01->00 during byte 2 -> all 5 bytes still sent, then idle stays 1.
- Hold tx_busy=1 when entering SEND -> tx_start stays 0 until busy falls, then pulses once.
- Assert rst_n=0 during WAIT_LO of byte 3 -> all outputs reach reset values asynchronously. After release, with the FIFOs non-empty, the new frame restarts from the header byte.
